// File: rtl/pong_game_ctrl_if.sv
`timescale 1ns/1ps
// Signal bundle between the pong game sequencer (master) and the renderer/button side (slave).
interface pong_game_ctrl_if;
  logic       vsync;
  logic       start;
  logic       l_up;
  logic       l_down;
  logic       r_up;
  logic       r_down;
  logic [9:0] l_pos;
  logic [9:0] r_pos;
  logic [9:0] x_ball_pos;
  logic [9:0] y_ball_pos;
  logic [3:0] l_score;
  logic [3:0] r_score;
  logic [1:0] state;
  logic       game_over;

  modport master (
    input  vsync, start, l_up, l_down, r_up, r_down,
    output l_pos, r_pos, x_ball_pos, y_ball_pos, l_score, r_score, state, game_over
  );

  modport slave (
    output vsync, start, l_up, l_down, r_up, r_down,
    input  l_pos, r_pos, x_ball_pos, y_ball_pos, l_score, r_score, state, game_over
  );
endinterface

// File: rtl/pong_game_ctrl.sv
`timescale 1ns/1ps
// Pong game sequencer: paddles, ball, scores and game FSM, advanced once per vsync rising edge.
// Define PONG_CPU_PLAYER_EN to make the right paddle track the ball instead of r_up/r_down.
module pong_game_ctrl #(
  parameter int SCREEN_W    = 800,
  parameter int SCREEN_H    = 600,
  parameter int PADDLE_W    = 20,
  parameter int PADDLE_H    = 150,
  parameter int BALL_SZ     = 10,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_DX     = 2,
  parameter int BALL_DY     = 2,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.master game
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE     = 2'd1,
    PLAY      = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(SERVE_DELAY + 1);

  // All geometry is handled in 11 bits so that sums near the screen edge never wrap.
  localparam logic [10:0] STEP     = 11'(PADDLE_STEP);
  localparam logic [10:0] DX       = 11'(BALL_DX);
  localparam logic [10:0] DY       = 11'(BALL_DY);
  localparam logic [10:0] PH       = 11'(PADDLE_H);
  localparam logic [10:0] BSZ      = 11'(BALL_SZ);
  localparam logic [10:0] PAD_MAX  = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] PAD_INIT = 11'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [10:0] Y_MAX    = 11'(SCREEN_H - BALL_SZ);
  localparam logic [10:0] X_LMIN   = 11'(PADDLE_W);
  localparam logic [10:0] X_LEDGE  = 11'(PADDLE_W + BALL_DX);
  localparam logic [10:0] X_RMAX   = 11'(SCREEN_W - PADDLE_W - BALL_SZ);
  localparam logic [10:0] X_CTR    = 11'((SCREEN_W - BALL_SZ) / 2);
  localparam logic [10:0] Y_CTR    = 11'((SCREEN_H - BALL_SZ) / 2);
  localparam logic [3:0]  WIN      = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY);

  state_t           state_q, state_d;
  logic             vsync_q;
  logic [9:0]       l_pos_q, l_pos_d;
  logic [9:0]       r_pos_q, r_pos_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             dir_x_q, dir_x_d;
  logic             dir_y_q, dir_y_d;
  logic [3:0]       l_score_q, l_score_d;
  logic [3:0]       r_score_q, r_score_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             tick;
  logic [9:0]       l_nxt, r_nxt;
  logic [10:0]      bx, by, x_v, y_v;
  logic             dx_v, dy_v;
  logic             miss_l, miss_r;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       l_score_inc, r_score_inc;

  function automatic logic [9:0] paddle_step(input logic [9:0] pos, input logic up,
                                             input logic down);
    logic [10:0] p;
    p = {1'b0, pos};
    if (up && !down)
      p = (p < STEP) ? 11'd0 : p - STEP;
    else if (down && !up)
      p = (p + STEP > PAD_MAX) ? PAD_MAX : p + STEP;
    return p[9:0];
  endfunction

  function automatic logic overlaps(input logic [10:0] ball_y, input logic [9:0] pad);
    logic [10:0] p;
    p = {1'b0, pad};
    return (ball_y + BSZ > p) && (ball_y < p + PH);
  endfunction

`ifdef PONG_CPU_PLAYER_EN
  function automatic logic [9:0] cpu_step(input logic [9:0] pos, input logic [9:0] ball_y);
    logic [10:0] c, b;
    c = {1'b0, pos} + 11'(PADDLE_H / 2);
    b = {1'b0, ball_y} + 11'(BALL_SZ / 2);
    return paddle_step(pos, b + 11'd8 < c, c + 11'd8 < b);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      vsync_q   <= 1'b0;
      l_pos_q   <= PAD_INIT[9:0];
      r_pos_q   <= PAD_INIT[9:0];
      x_q       <= X_CTR[9:0];
      y_q       <= Y_CTR[9:0];
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      l_score_q <= 4'd0;
      r_score_q <= 4'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      vsync_q   <= game.vsync;
      l_pos_q   <= l_pos_d;
      r_pos_q   <= r_pos_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      l_score_q <= l_score_d;
      r_score_q <= r_score_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    l_pos_d     = l_pos_q;
    r_pos_d     = r_pos_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    l_score_d   = l_score_q;
    r_score_d   = r_score_q;
    cnt_d       = cnt_q;

    tick        = game.vsync & ~vsync_q;
    cnt_inc     = cnt_q + CNT_W'(1);
    l_score_inc = l_score_q + 4'd1;
    r_score_inc = r_score_q + 4'd1;
    l_nxt       = paddle_step(l_pos_q, game.l_up, game.l_down);
`ifdef PONG_CPU_PLAYER_EN
    r_nxt       = cpu_step(r_pos_q, y_q);
`else
    r_nxt       = paddle_step(r_pos_q, game.r_up, game.r_down);
`endif
    bx          = {1'b0, x_q};
    by          = {1'b0, y_q};
    x_v         = bx;
    y_v         = by;
    dx_v        = dir_x_q;
    dy_v        = dir_y_q;
    miss_l      = 1'b0;
    miss_r      = 1'b0;

    // Vertical move with bounce off top/bottom.
    if (dir_y_q) begin
      if (by + DY > Y_MAX) begin
        y_v  = Y_MAX;
        dy_v = 1'b0;
      end else begin
        y_v  = by + DY;
      end
    end else begin
      if (by < DY) begin
        y_v  = 11'd0;
        dy_v = 1'b1;
      end else begin
        y_v  = by - DY;
      end
    end

    // Horizontal move; miss_l means the ball got past the left paddle.
    if (!dir_x_q && bx < X_LEDGE) begin
      if (overlaps(by, l_pos_q)) begin
        x_v  = X_LMIN;
        dx_v = 1'b1;
      end else begin
        miss_l = 1'b1;
      end
    end else if (dir_x_q && bx + DX > X_RMAX) begin
      if (overlaps(by, r_pos_q)) begin
        x_v  = X_RMAX;
        dx_v = 1'b0;
      end else begin
        miss_r = 1'b1;
      end
    end else begin
      x_v = dir_x_q ? bx + DX : bx - DX;
    end

    case (state_q)
      IDLE: begin
        if (game.start) begin
          state_d = SERVE;
          cnt_d   = '0;
        end
      end
      SERVE: begin
        if (tick) begin
          l_pos_d = l_nxt;
          r_pos_d = r_nxt;
          cnt_d   = cnt_inc;
          if (cnt_inc == SERVE_LAST)
            state_d = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          l_pos_d = l_nxt;
          r_pos_d = r_nxt;
          if (miss_l || miss_r) begin
            // Recentre and serve toward whoever conceded; vertical direction is kept.
            x_d     = X_CTR[9:0];
            y_d     = Y_CTR[9:0];
            dir_x_d = miss_r;
            cnt_d   = '0;
            state_d = SERVE;
            if (miss_l) begin
              r_score_d = r_score_inc;
              if (r_score_inc == WIN) state_d = GAME_OVER;
            end else begin
              l_score_d = l_score_inc;
              if (l_score_inc == WIN) state_d = GAME_OVER;
            end
          end else begin
            x_d     = x_v[9:0];
            y_d     = y_v[9:0];
            dir_x_d = dx_v;
            dir_y_d = dy_v;
          end
        end
      end
      GAME_OVER: begin
        if (game.start) begin
          l_score_d = 4'd0;
          r_score_d = 4'd0;
          x_d       = X_CTR[9:0];
          y_d       = Y_CTR[9:0];
          cnt_d     = '0;
          state_d   = SERVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign game.l_pos      = l_pos_q;
  assign game.r_pos      = r_pos_q;
  assign game.x_ball_pos = x_q;
  assign game.y_ball_pos = y_q;
  assign game.l_score    = l_score_q;
  assign game.r_score    = r_score_q;
  assign game.state      = state_q;
  assign game.game_over  = (state_q == GAME_OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for pong_game_ctrl: directed scenarios plus randomized play against a frame-level model.
module tb_pong_game_ctrl;
  localparam int WIN = 2;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pong_game_ctrl_if game();

  pong_game_ctrl #(.WIN_SCORE(WIN)) dut (
    .clk  (clk),
    .reset(reset),
    .game (game)
  );

  always #5 clk = ~clk;

  // Reference model state, plain integers.
  int m_l, m_r, m_x, m_y, m_dx, m_dy, m_ls, m_rs, m_st, m_cnt, m_vq;

  task automatic model_reset();
    m_l = 225; m_r = 225; m_x = 395; m_y = 295; m_dx = 1; m_dy = 1;
    m_ls = 0; m_rs = 0; m_st = 0; m_cnt = 0; m_vq = 0;
  endtask

  function automatic int move(int p, bit up, bit dn);
    if (up && !dn) return (p - 4 < 0) ? 0 : p - 4;
    if (dn && !up) return (p + 4 > 450) ? 450 : p + 4;
    return p;
  endfunction

  task automatic model_frame();
    int ol, orr, nx, ny, ndx, ndy;
    bit miss_l, miss_r;
    ol = m_l; orr = m_r;
    m_l = move(m_l, game.l_up, game.l_down);
`ifdef PONG_CPU_PLAYER_EN
    m_r = move(m_r, (m_y + 5) + 8 < (m_r + 75), (m_r + 75) + 8 < (m_y + 5));
`else
    m_r = move(m_r, game.r_up, game.r_down);
`endif
    if (m_st == 1) begin
      m_cnt++;
      if (m_cnt == 60) m_st = 2;
      return;
    end
    ny = m_y + (m_dy != 0 ? 2 : -2); ndy = m_dy;
    if (ny > 590) begin ny = 590; ndy = 0; end
    if (ny < 0) begin ny = 0; ndy = 1; end
    nx = m_x + (m_dx != 0 ? 2 : -2); ndx = m_dx;
    miss_l = 0; miss_r = 0;
    if (m_dx == 0 && m_x < 22) begin
      if (m_y + 10 > ol && m_y < ol + 150) begin nx = 20; ndx = 1; end
      else miss_l = 1;
    end else if (m_dx != 0 && m_x + 2 > 770) begin
      if (m_y + 10 > orr && m_y < orr + 150) begin nx = 770; ndx = 0; end
      else miss_r = 1;
    end
    if (miss_l || miss_r) begin
      if (miss_l) m_rs++; else m_ls++;
      m_x = 395; m_y = 295; m_dx = miss_l ? 0 : 1;
      if (m_ls == WIN || m_rs == WIN) m_st = 3;
      else begin m_st = 1; m_cnt = 0; end
    end else begin
      m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
    end
  endtask

  task automatic model_cycle();
    bit tk;
    if (reset) begin model_reset(); return; end
    tk = game.vsync && (m_vq == 0);
    m_vq = game.vsync;
    case (m_st)
      0: if (game.start) begin m_st = 1; m_cnt = 0; end
      3: if (game.start) begin
           m_ls = 0; m_rs = 0; m_x = 395; m_y = 295; m_st = 1; m_cnt = 0;
         end
      default: if (tk) model_frame();
    endcase
  endtask

  function automatic logic [50:0] obs();
    return {game.l_pos, game.r_pos, game.x_ball_pos, game.y_ball_pos,
            game.l_score, game.r_score, game.state, game.game_over};
  endfunction

  function automatic logic [50:0] expv();
    return {10'(m_l), 10'(m_r), 10'(m_x), 10'(m_y), 4'(m_ls), 4'(m_rs), 2'(m_st), (m_st == 3)};
  endfunction

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(int hi, int lo);
    game.vsync = 1'b1;
    repeat (hi) step();
    game.vsync = 1'b0;
    repeat (lo) step();
  endtask

  task automatic clear_inputs();
    game.vsync = 0; game.start = 0;
    game.l_up = 0; game.l_down = 0; game.r_up = 0; game.r_down = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic start_pulse();
    game.start = 1'b1;
    step();
    game.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [50:0] rv;
    rv = {10'd225, 10'd225, 10'd395, 10'd295, 4'd0, 4'd0, 2'd0, 1'b0};
    do_reset();
    checks++;
    if (obs() !== rv) begin
      errors++; $display("FAIL reset_values: got=%h want=%h", obs(), rv);
    end
    repeat (3) frame(2, 2);
    checks++;
    if (obs() !== rv) begin
      errors++; $display("FAIL idle_after_vsync: got=%h want=%h", obs(), rv);
    end
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL idle_model: got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_paddles();
    do_reset();
    start_pulse();
    game.l_up = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      frame(1, 2);
      if (t == 56 || t == 57 || t == 60) begin
        checks++;
        if (game.l_pos !== ((t == 56) ? 10'd1 : 10'd0)) begin
          errors++; $display("FAIL l_up_sat t=%0d: got=%0d want=%0d", t, game.l_pos, (t == 56) ? 1 : 0);
        end
      end
    end
    game.l_up = 1'b0; game.l_down = 1'b1;
    for (int t = 1; t <= 115; t++) begin
      frame(1, 2);
      if (t == 112 || t == 113 || t == 115) begin
        checks++;
        if (game.l_pos !== ((t == 112) ? 10'd448 : 10'd450)) begin
          errors++; $display("FAIL l_down_sat t=%0d: got=%0d want=%0d", t, game.l_pos, (t == 112) ? 448 : 450);
        end
      end
    end
    game.l_up = 1'b1;
    repeat (3) frame(1, 2);
    checks++;
    if (game.l_pos !== 10'd450) begin
      errors++; $display("FAIL both_hold: got=%0d want=450", game.l_pos);
    end
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL paddles_model: got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_serve_bounce();
    do_reset();
    start_pulse();
    for (int t = 1; t <= 61; t++) begin
      frame(1, 2);
      if (t == 59 || t == 60) begin
        checks++;
        if (game.state !== ((t == 59) ? 2'd1 : 2'd2)) begin
          errors++; $display("FAIL serve_state t=%0d: got=%0d want=%0d", t, game.state, (t == 59) ? 1 : 2);
        end
      end
    end
    checks++;
    if ({game.x_ball_pos, game.y_ball_pos} !== {10'd397, 10'd297}) begin
      errors++; $display("FAIL first_move: got=(%0d,%0d) want=(397,297)", game.x_ball_pos, game.y_ball_pos);
    end
    for (int p = 2; p <= 149; p++) begin
      frame(1, 2);
      if (p >= 147) begin
        checks++;
        if (game.y_ball_pos !== ((p == 147) ? 10'd589 : (p == 148) ? 10'd590 : 10'd588)) begin
          errors++; $display("FAIL bottom_bounce p=%0d: got=%0d", p, game.y_ball_pos);
        end
      end
    end
    game.vsync = 1'b1;
    repeat (20) step();
    checks++;
    if ({game.x_ball_pos, game.y_ball_pos} !== {10'd695, 10'd586}) begin
      errors++; $display("FAIL vsync_held: got=(%0d,%0d) want=(695,586)", game.x_ball_pos, game.y_ball_pos);
    end
    game.vsync = 1'b0;
    step();
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL bounce_model: got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_miss_hit();
    do_reset();
    start_pulse();
    game.r_up = 1'b1;
    for (int t = 1; t <= 248; t++) begin
      frame(1, 2);
      if (t == 247) begin
        checks++;
        if ({game.x_ball_pos, game.y_ball_pos} !== {10'd769, 10'd512}) begin
          errors++; $display("FAIL pre_miss: got=(%0d,%0d) want=(769,512)", game.x_ball_pos, game.y_ball_pos);
        end
      end
    end
    checks++;
    if ({game.l_score, game.x_ball_pos, game.y_ball_pos, game.state} !== {4'd1, 10'd395, 10'd295, 2'd1}) begin
      errors++; $display("FAIL right_miss: got ls=%0d (%0d,%0d) st=%0d want ls=1 (395,295) st=1",
                         game.l_score, game.x_ball_pos, game.y_ball_pos, game.state);
    end
    do_reset();
    start_pulse();
    game.r_down = 1'b1;
    for (int t = 1; t <= 249; t++) begin
      frame(1, 2);
      if (t >= 248) begin
        checks++;
        if (game.x_ball_pos !== ((t == 248) ? 10'd770 : 10'd768)) begin
          errors++; $display("FAIL right_hit t=%0d: got=%0d", t, game.x_ball_pos);
        end
      end
    end
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL hit_model: got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_win_restart();
    logic [50:0] rv;
    rv = {10'd225, 10'd225, 10'd395, 10'd295, 4'd0, 4'd0, 2'd0, 1'b0};
    do_reset();
    start_pulse();
    game.r_up = 1'b1;
    repeat (248) frame(1, 2);
    game.r_up = 1'b0; game.r_down = 1'b1;
    for (int i = 0; i < 400 && game.state !== 2'd3; i++) frame(1, 2);
    checks++;
    if ({game.state, game.game_over, game.l_score} !== {2'd3, 1'b1, 4'd2}) begin
      errors++; $display("FAIL game_over: got st=%0d go=%0d ls=%0d want st=3 go=1 ls=2",
                         game.state, game.game_over, game.l_score);
    end
    game.l_up = 1; game.l_down = 1; game.r_up = 1;
    repeat (10) frame(1, 2);
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL frozen: got=%h want=%h", obs(), expv());
    end
    clear_inputs();
    start_pulse();
    checks++;
    if ({game.l_score, game.r_score, game.state, game.game_over} !== {4'd0, 4'd0, 2'd1, 1'b0}) begin
      errors++; $display("FAIL restart: got ls=%0d rs=%0d st=%0d want 0 0 1",
                         game.l_score, game.r_score, game.state);
    end
    repeat (65) frame(1, 2);
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL replay_model: got=%h want=%h", obs(), expv());
    end
    reset = 1'b1; game.vsync = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (obs() !== rv) begin
      errors++; $display("FAIL mid_play_reset: got=%h want=%h", obs(), rv);
    end
    game.vsync = 1'b0;
    step();
  endtask

  task automatic test_random();
    int hi, lo;
    do_reset();
    for (int f = 0; f < 1500; f++) begin
      game.l_up   = ($urandom_range(0, 2) == 0);
      game.l_down = ($urandom_range(0, 2) == 0);
      game.r_up   = ($urandom_range(0, 2) == 0);
      game.r_down = ($urandom_range(0, 2) == 0);
      game.start  = ($urandom_range(0, 30) == 0);
      reset       = ($urandom_range(0, 700) == 0);
      hi = $urandom_range(1, 3);
      lo = $urandom_range(1, 3);
      game.vsync = 1'b1;
      repeat (hi) begin
        step();
        game.start = 1'b0;
        reset = 1'b0;
      end
      game.vsync = 1'b0;
      repeat (lo) step();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random f=%0d: got=%h want=%h", f, obs(), expv());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_paddles();
    test_serve_bounce();
    test_miss_hit();
    test_win_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
